// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: shares one write port between the
// pipeline write-back stage (P, priority) and the multiply/divide unit (M).
// An age counter forces an M grant after MAX_WAIT consecutive denials.
// The winning write is registered and presented one cycle later.
module regfile_write_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p_valid,
    output logic              p_ready,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_data,
    input  logic              m_valid,
    output logic              m_ready,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              m_forced
);

    // Four bits cover the full legal MAX_WAIT range of 1..15.
    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;
    logic       force_m;
    logic       p_xfer;
    logic       m_xfer;

    // Grant decode: P wins unless M has aged out.
    always_comb begin
        force_m = m_valid && (wait_cnt == MAX_CNT);
        p_ready = !force_m;
        m_ready = !p_valid || force_m;
        p_xfer  = p_valid && p_ready;
        m_xfer  = m_valid && m_ready;
    end

    // Age counter: counts consecutive cycles M is held off, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!m_valid || m_xfer) begin
            wait_cnt <= '0;
        end else if (wait_cnt != MAX_CNT) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // Write-port register: load the winner, suppress the enable for r0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (p_xfer) begin
            wr_en   <= (p_addr != '0);
            wr_addr <= p_addr;
            wr_data <= p_data;
        end else if (m_xfer) begin
            wr_en   <= (m_addr != '0);
            wr_addr <= m_addr;
            wr_data <= m_data;
        end else begin
            wr_en   <= 1'b0;
        end
    end

    // Flags the write slot that came from an aged-out M grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_forced <= 1'b0;
        end else begin
            m_forced <= m_xfer && force_m;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter against a
// cycle-level reference model of the arbitration rules.
module tb_regfile_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          p_valid = 1'b0;
    logic          p_ready;
    logic [AW-1:0] p_addr = '0;
    logic [DW-1:0] p_data = '0;
    logic          m_valid = 1'b0;
    logic          m_ready;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          m_forced;

    regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .p_valid(p_valid), .p_ready(p_ready), .p_addr(p_addr), .p_data(p_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_data(m_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .m_forced(m_forced)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: M's consecutive-denial count plus the expected
    // contents of the write port after each edge.
    int            denials = 0;
    logic          e_en = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_data = '0;
    logic          e_forced = 1'b0;
    bit            p_x, m_x, aged;

    task automatic model_reset();
        denials = 0; e_en = 0; e_addr = '0; e_data = '0; e_forced = 0;
        p_x = 0; m_x = 0;
    endtask

    // One clock: check grants mid-cycle, advance model, check outputs.
    task automatic cycle();
        logic          pv, mv;
        logic [AW-1:0] pa, ma;
        logic [DW-1:0] pd, md;
        @(negedge clk);
        pv = p_valid; mv = m_valid; pa = p_addr; ma = m_addr; pd = p_data; md = m_data;
        aged = mv && (denials == MW);
        if (pv && mv) begin
            m_x = aged;
            p_x = !aged;
        end else begin
            p_x = pv;
            m_x = mv;
        end
        check("p_ready", p_ready, !aged);
        check("m_ready", m_ready, aged || !pv);
        @(posedge clk);
        #1;
        if (p_x) begin
            e_en = (pa != 0); e_addr = pa; e_data = pd;
        end else if (m_x) begin
            e_en = (ma != 0); e_addr = ma; e_data = md;
        end else begin
            e_en = 0;
        end
        e_forced = m_x && aged;
        if (!mv || m_x) denials = 0;
        else if (denials < MW) denials++;
        check("wr_en", wr_en, e_en);
        check("wr_addr", wr_addr, e_addr);
        check("wr_data", wr_data, e_data);
        check("m_forced", m_forced, e_forced);
    endtask

    initial begin
        int m_win;
        // Reset held with both requesters active.
        p_valid = 1; m_valid = 1; p_addr = 5'd4; m_addr = 5'd6;
        p_data = 32'hAAAA5555; m_data = 32'h5555AAAA;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_m_forced", m_forced, 0);
        p_valid = 0; m_valid = 0;
        model_reset();
        rst_n = 1;

        // Single P write.
        p_valid = 1; p_addr = 5'd7; p_data = 32'hDEADBEEF;
        cycle();
        p_valid = 0;
        check("single_en", wr_en, 1);
        check("single_addr", wr_addr, 7);
        check("single_data", wr_data, 32'hDEADBEEF);
        cycle();
        check("single_idle_en", wr_en, 0);

        // Aging: P and M both continuously valid.
        m_win = -1;
        m_valid = 1; m_addr = 5'd9; m_data = 32'h0BADF00D;
        for (int i = 0; i < 5; i++) begin
            p_valid = 1; p_addr = 5'(i + 10); p_data = $urandom;
            cycle();
            if (m_x && m_win < 0) m_win = i;
        end
        check("age_grant_cycle", m_win, 4);
        check("age_addr", wr_addr, 9);
        check("age_forced", m_forced, 1);
        m_valid = 0;
        cycle();
        p_valid = 0;
        check("age_cleared", denials, 0);

        // M alone.
        m_valid = 1; m_addr = 5'd3; m_data = 32'h12345678;
        cycle();
        m_valid = 0;
        check("m_alone_en", wr_en, 1);
        check("m_alone_addr", wr_addr, 3);
        check("m_alone_data", wr_data, 32'h12345678);
        check("m_alone_forced", m_forced, 0);

        // Register 0 discard.
        p_valid = 1; p_addr = 5'd0; p_data = 32'hFFFFFFFF;
        cycle();
        p_valid = 0;
        check("r0_en", wr_en, 0);
        check("r0_addr", wr_addr, 0);
        check("r0_data", wr_data, 32'hFFFFFFFF);

        // Back-to-back P writes r1..r8.
        for (int i = 1; i <= 8; i++) begin
            p_valid = 1; p_addr = 5'(i); p_data = 32'(i * 32'h01010101);
            cycle();
            check("b2b_en", wr_en, 1);
            check("b2b_addr", wr_addr, i);
        end
        p_valid = 0;
        cycle();

        // Random traffic obeying the hold-until-transfer protocol,
        // with one asynchronous reset mid-stream.
        for (int n = 0; n < 3000; n++) begin
            if (!p_valid || p_x) begin
                p_valid = ($urandom_range(0, 3) != 0);
                p_addr = 5'($urandom_range(0, 31));
                p_data = $urandom;
            end
            if (!m_valid || m_x) begin
                m_valid = ($urandom_range(0, 2) == 0);
                m_addr = 5'($urandom_range(0, 31));
                m_data = $urandom;
            end
            if (n == 1500) begin
                #2;
                rst_n = 0;
                #1;
                check("async_rst_en", wr_en, 0);
                check("async_rst_addr", wr_addr, 0);
                check("async_rst_data", wr_data, 0);
                check("async_rst_forced", m_forced, 0);
                @(posedge clk);
                #1;
                model_reset();
                p_valid = 0; m_valid = 0;
                rst_n = 1;
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
